// File: rtl/decode_int_sched_if.sv
// Bundle between the decode pipeline (master) and the interrupt scheduler (slave).
// Carries nmi_req/nmi_vector only when DECODE_INT_SCHED_NMI_EN is defined.
interface decode_int_sched_if #(
  parameter int unsigned VECW = 8
);
`ifdef DECODE_INT_SCHED_NMI_EN
  logic            nmi_req;
  logic [VECW-1:0] nmi_vector;
`endif
  logic            int_req;
  logic [VECW-1:0] int_vector;
  logic [31:0]     eflags_reg;
  logic            s0_valid;
  logic            s0_ready;
  logic            s0_rom_in_control;
  logic            iretd;
  logic            iretd_done;
  logic            flush;
  logic            handle_int_done;
  logic            handle_int;
  logic            iretd_halt;
  logic            int_ack;
  logic [VECW-1:0] int_vector_q;
  logic            busy;
  logic            timeout_err;

  modport master (
`ifdef DECODE_INT_SCHED_NMI_EN
    output nmi_req, nmi_vector,
`endif
    output int_req, int_vector, eflags_reg, s0_valid, s0_ready, s0_rom_in_control,
    output iretd, iretd_done, flush, handle_int_done,
    input  handle_int, iretd_halt, int_ack, int_vector_q, busy, timeout_err
  );

  modport slave (
`ifdef DECODE_INT_SCHED_NMI_EN
    input  nmi_req, nmi_vector,
`endif
    input  int_req, int_vector, eflags_reg, s0_valid, s0_ready, s0_rom_in_control,
    input  iretd, iretd_done, flush, handle_int_done,
    output handle_int, iretd_halt, int_ack, int_vector_q, busy, timeout_err
  );
endinterface

// File: rtl/decode_int_sched.sv
// Interrupt injection scheduler: latches a request, waits for a decode boundary, injects the ROM
// sequence and watches for completion. Optional NMI path under DECODE_INT_SCHED_NMI_EN.
module decode_int_sched #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned VECW    = 8
) (
  input logic               clk,
  input logic               reset,
  decode_int_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BND  = 3'd1,
    INJECT    = 3'd2,
    WAIT_DONE = 3'd3,
    IRET_HOLD = 3'd4
  } state_t;

  state_t          state, state_n;
  logic            pending, pending_n;
  logic [VECW-1:0] vec_q, vec_n;
  logic [15:0]     cnt, cnt_n;
  logic            terr, terr_n;
  logic            ack, ack_n;
  logic            boundary, take_int, clr_pend;
  logic            eflags_unused;
`ifdef DECODE_INT_SCHED_NMI_EN
  logic            nmi_q, nmi_n, halt_q, halt_n, take_nmi;
`endif

  assign eflags_unused = ^{bus.eflags_reg[31:10], bus.eflags_reg[8:0]};
  assign boundary = !bus.s0_rom_in_control && (!bus.s0_valid || bus.s0_ready);
  assign take_int = !pending && bus.int_req && bus.eflags_reg[9];
`ifdef DECODE_INT_SCHED_NMI_EN
  assign take_nmi = !pending && bus.nmi_req;
`endif

  always_comb begin
    state_n   = state;
    pending_n = pending;
    vec_n     = vec_q;
    cnt_n     = '0;
    terr_n    = terr;
    ack_n     = 1'b0;
    clr_pend  = 1'b0;
`ifdef DECODE_INT_SCHED_NMI_EN
    nmi_n     = nmi_q;
    halt_n    = halt_q;
`endif
    unique case (state)
      IDLE: begin
        if (bus.s0_valid && bus.iretd) state_n = IRET_HOLD;
        else if (pending)              state_n = WAIT_BND;
      end
      WAIT_BND: begin
        if (!bus.flush && boundary) state_n = INJECT;
      end
      INJECT: state_n = WAIT_DONE;
      WAIT_DONE: begin
        cnt_n = cnt + 16'd1;
        if (bus.handle_int_done) begin
          state_n  = IDLE;
          ack_n    = 1'b1;
          clr_pend = 1'b1;
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          state_n  = IDLE;
          terr_n   = 1'b1;
          clr_pend = 1'b1;
        end
      end
      IRET_HOLD: begin
`ifdef DECODE_INT_SCHED_NMI_EN
        // An NMI pre-empts the IRETD wait; the front end stays halted until it is acknowledged.
        if (pending && nmi_q) begin
          state_n = WAIT_BND;
          halt_n  = 1'b1;
        end else
`endif
        if (bus.iretd_done || bus.flush) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Completion releases the old request before a new one can be latched on a later cycle.
    if (clr_pend) begin
      pending_n = 1'b0;
`ifdef DECODE_INT_SCHED_NMI_EN
      nmi_n     = 1'b0;
      halt_n    = 1'b0;
    end else if (take_nmi) begin
      pending_n = 1'b1;
      nmi_n     = 1'b1;
      vec_n     = bus.nmi_vector;
`endif
    end else if (take_int) begin
      pending_n = 1'b1;
      vec_n     = bus.int_vector;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      vec_q   <= '0;
      cnt     <= '0;
      terr    <= 1'b0;
      ack     <= 1'b0;
`ifdef DECODE_INT_SCHED_NMI_EN
      nmi_q   <= 1'b0;
      halt_q  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      pending <= pending_n;
      vec_q   <= vec_n;
      cnt     <= cnt_n;
      terr    <= terr_n;
      ack     <= ack_n;
`ifdef DECODE_INT_SCHED_NMI_EN
      nmi_q   <= nmi_n;
      halt_q  <= halt_n;
`endif
    end
  end

  assign bus.handle_int   = (state == INJECT) || (state == WAIT_DONE);
`ifdef DECODE_INT_SCHED_NMI_EN
  assign bus.iretd_halt   = (state == IRET_HOLD) || halt_q;
`else
  assign bus.iretd_halt   = (state == IRET_HOLD);
`endif
  assign bus.int_ack      = ack;
  assign bus.int_vector_q = vec_q;
  assign bus.busy         = (state != IDLE);
  assign bus.timeout_err  = terr;

endmodule

// File: tb/tb_decode_int_sched.sv
// Bench for decode_int_sched: directed scenarios plus a randomized run against a cycle-level
// behavioural model. u_dut uses TIMEOUT=12, u_dut4 uses TIMEOUT=4 and shares all stimulus.
module tb_decode_int_sched;
  localparam int unsigned VECW = 8;
  localparam int unsigned TO_A = 12;
  localparam int unsigned TO_B = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  decode_int_sched_if #(.VECW(VECW)) ifa ();
  decode_int_sched_if #(.VECW(VECW)) ifb ();

  decode_int_sched #(.TIMEOUT(TO_A), .VECW(VECW)) u_dut  (.clk(clk), .reset(reset), .bus(ifa.slave));
  decode_int_sched #(.TIMEOUT(TO_B), .VECW(VECW)) u_dut4 (.clk(clk), .reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  assign ifb.int_req           = ifa.int_req;
  assign ifb.int_vector        = ifa.int_vector;
  assign ifb.eflags_reg        = ifa.eflags_reg;
  assign ifb.s0_valid          = ifa.s0_valid;
  assign ifb.s0_ready          = ifa.s0_ready;
  assign ifb.s0_rom_in_control = ifa.s0_rom_in_control;
  assign ifb.iretd             = ifa.iretd;
  assign ifb.iretd_done        = ifa.iretd_done;
  assign ifb.flush             = ifa.flush;
  assign ifb.handle_int_done   = ifa.handle_int_done;
`ifdef DECODE_INT_SCHED_NMI_EN
  assign ifb.nmi_req           = ifa.nmi_req;
  assign ifb.nmi_vector        = ifa.nmi_vector;
`endif

  // status bits: {handle_int, iretd_halt, int_ack, busy, timeout_err}
  logic [4:0] st_a, st_b;
  assign st_a = {ifa.handle_int, ifa.iretd_halt, ifa.int_ack, ifa.busy, ifa.timeout_err};
  assign st_b = {ifb.handle_int, ifb.iretd_halt, ifb.int_ack, ifb.busy, ifb.timeout_err};

  task automatic idle_inputs();
    ifa.int_req = 1'b0; ifa.int_vector = '0; ifa.eflags_reg = '0;
    ifa.s0_valid = 1'b0; ifa.s0_ready = 1'b1; ifa.s0_rom_in_control = 1'b0;
    ifa.iretd = 1'b0; ifa.iretd_done = 1'b0; ifa.flush = 1'b0; ifa.handle_int_done = 1'b0;
`ifdef DECODE_INT_SCHED_NMI_EN
    ifa.nmi_req = 1'b0; ifa.nmi_vector = '0;
`endif
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic raise_int(input logic [VECW-1:0] v);
    ifa.int_req = 1'b1; ifa.eflags_reg = 32'h0000_0200; ifa.int_vector = v;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if (st_a !== 5'b0) begin errors++; $display("FAIL reset_status_a: got %b want 00000", st_a); end
    checks++; if (st_b !== 5'b0) begin errors++; $display("FAIL reset_status_b: got %b want 00000", st_b); end
    checks++; if (ifa.int_vector_q !== 8'h00) begin errors++; $display("FAIL reset_vec_a: got %h want 00", ifa.int_vector_q); end
    checks++; if (ifb.int_vector_q !== 8'h00) begin errors++; $display("FAIL reset_vec_b: got %h want 00", ifb.int_vector_q); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (st_a !== 5'b0) begin errors++; $display("FAIL reset_release: got %b want 00000", st_a); end
  endtask

  task automatic test_basic();
    do_reset();
    raise_int(8'h21);
    tick();
    ifa.int_req = 1'b0; ifa.int_vector = 8'hFF;
    checks++; if (ifa.int_vector_q !== 8'h21) begin errors++; $display("FAIL basic_capture: got %h want 21", ifa.int_vector_q); end
    checks++; if (st_a !== 5'b00000) begin errors++; $display("FAIL basic_latch: got %b want 00000", st_a); end
    tick();
    checks++; if (st_a !== 5'b00010) begin errors++; $display("FAIL basic_wait_bnd: got %b want 00010", st_a); end
    tick();
    checks++; if (st_a !== 5'b10010) begin errors++; $display("FAIL basic_inject: got %b want 10010", st_a); end
    tick(4);
    checks++; if (st_a !== 5'b10010) begin errors++; $display("FAIL basic_wait_done: got %b want 10010", st_a); end
    ifa.handle_int_done = 1'b1;
    tick();
    ifa.handle_int_done = 1'b0;
    checks++; if (st_a !== 5'b00100) begin errors++; $display("FAIL basic_ack: got %b want 00100", st_a); end
    checks++; if (ifa.int_vector_q !== 8'h21) begin errors++; $display("FAIL basic_vec_hold: got %h want 21", ifa.int_vector_q); end
    tick();
    checks++; if (st_a !== 5'b00000) begin errors++; $display("FAIL basic_ack_once: got %b want 00000", st_a); end
  endtask

  task automatic test_if_mask();
    do_reset();
    ifa.int_req = 1'b1; ifa.eflags_reg = 32'hFFFF_FDFF; ifa.int_vector = 8'h55;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (st_a !== 5'b00000) begin errors++; $display("FAIL ifmask_blocked[%0d]: got %b want 00000", i, st_a); end
    end
    checks++; if (ifa.int_vector_q !== 8'h00) begin errors++; $display("FAIL ifmask_vec: got %h want 00", ifa.int_vector_q); end
    ifa.eflags_reg = 32'h0000_0200;
    tick();
    ifa.int_req = 1'b0;
    checks++; if (ifa.int_vector_q !== 8'h55) begin errors++; $display("FAIL ifmask_capture: got %h want 55", ifa.int_vector_q); end
    tick(2);
    checks++; if (st_a !== 5'b10010) begin errors++; $display("FAIL ifmask_inject: got %b want 10010", st_a); end
  endtask

  task automatic test_boundary();
    do_reset();
    ifa.s0_rom_in_control = 1'b1; ifa.s0_valid = 1'b1; ifa.s0_ready = 1'b1;
    raise_int(8'h3C);
    tick();
    ifa.int_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ifa.flush = (i == 4);
      tick();
      checks++; if (st_a !== 5'b00010) begin errors++; $display("FAIL bnd_hold[%0d]: got %b want 00010", i, st_a); end
    end
    ifa.flush = 1'b0; ifa.s0_rom_in_control = 1'b0;
    tick();
    checks++; if (st_a !== 5'b10010) begin errors++; $display("FAIL bnd_inject: got %b want 10010", st_a); end
    checks++; if (ifa.int_vector_q !== 8'h3C) begin errors++; $display("FAIL bnd_vec: got %h want 3c", ifa.int_vector_q); end
  endtask

  task automatic test_iretd();
    do_reset();
    ifa.iretd = 1'b1; ifa.s0_valid = 1'b1;
    raise_int(8'h47);
    tick();
    checks++; if (st_a !== 5'b01010) begin errors++; $display("FAIL iretd_enter: got %b want 01010", st_a); end
    ifa.iretd = 1'b0; ifa.s0_valid = 1'b0; ifa.int_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (st_a !== 5'b01010) begin errors++; $display("FAIL iretd_hold[%0d]: got %b want 01010", i, st_a); end
    end
    ifa.iretd_done = 1'b1;
    tick();
    ifa.iretd_done = 1'b0;
    checks++; if (st_a !== 5'b00000) begin errors++; $display("FAIL iretd_exit: got %b want 00000", st_a); end
    tick(2);
    checks++; if (st_a !== 5'b10010) begin errors++; $display("FAIL iretd_deferred_inject: got %b want 10010", st_a); end
    checks++; if (ifa.int_vector_q !== 8'h47) begin errors++; $display("FAIL iretd_vec: got %h want 47", ifa.int_vector_q); end
    tick();
    ifa.handle_int_done = 1'b1;
    tick();
    ifa.handle_int_done = 1'b0;
    checks++; if (st_a !== 5'b00100) begin errors++; $display("FAIL iretd_ack: got %b want 00100", st_a); end
  endtask

  task automatic test_timeout();
    do_reset();
    raise_int(8'h66);
    tick();
    ifa.int_req = 1'b0;
    tick(2);
    checks++; if (st_b !== 5'b10010) begin errors++; $display("FAIL to_inject: got %b want 10010", st_b); end
    tick(4);
    checks++; if (st_b !== 5'b10010) begin errors++; $display("FAIL to_fourth_cycle: got %b want 10010", st_b); end
    tick();
    checks++; if (st_b !== 5'b00001) begin errors++; $display("FAIL to_fire: got %b want 00001", st_b); end
    checks++; if (st_a !== 5'b10010) begin errors++; $display("FAIL to_long_limit: got %b want 10010", st_a); end
    tick();
    checks++; if (st_b !== 5'b00001) begin errors++; $display("FAIL to_sticky: got %b want 00001", st_b); end
    ifa.handle_int_done = 1'b1;
    tick();
    ifa.handle_int_done = 1'b0;
    checks++; if (st_b !== 5'b00001) begin errors++; $display("FAIL to_late_done_ignored: got %b want 00001", st_b); end
    checks++; if (st_a !== 5'b00100) begin errors++; $display("FAIL to_long_ack: got %b want 00100", st_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    raise_int(8'h21);
    tick();
    ifa.int_req = 1'b0;
    tick(3);
    raise_int(8'h99);
    ifa.handle_int_done = 1'b1;
    tick();
    ifa.handle_int_done = 1'b0;
    checks++; if (st_a !== 5'b00100) begin errors++; $display("FAIL b2b_ack: got %b want 00100", st_a); end
    checks++; if (ifa.int_vector_q !== 8'h21) begin errors++; $display("FAIL b2b_old_vec: got %h want 21", ifa.int_vector_q); end
    tick();
    ifa.int_req = 1'b0;
    checks++; if (ifa.int_vector_q !== 8'h99) begin errors++; $display("FAIL b2b_new_vec: got %h want 99", ifa.int_vector_q); end
    checks++; if (st_a !== 5'b00000) begin errors++; $display("FAIL b2b_idle: got %b want 00000", st_a); end
    tick(2);
    checks++; if (st_a !== 5'b10010) begin errors++; $display("FAIL b2b_reinject: got %b want 10010", st_a); end
  endtask

  task automatic test_async_reset();
    do_reset();
    raise_int(8'h5A);
    tick();
    ifa.int_req = 1'b0;
    tick(3);
    checks++; if (st_a !== 5'b10010) begin errors++; $display("FAIL areset_pre: got %b want 10010", st_a); end
    #2 reset = 1'b0;
    #1;
    checks++; if (st_a !== 5'b00000) begin errors++; $display("FAIL areset_immediate_a: got %b want 00000", st_a); end
    checks++; if (st_b !== 5'b00000) begin errors++; $display("FAIL areset_immediate_b: got %b want 00000", st_b); end
    checks++; if (ifa.int_vector_q !== 8'h00) begin errors++; $display("FAIL areset_vec: got %h want 00", ifa.int_vector_q); end
    @(negedge clk);
    ifa.handle_int_done = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    ifa.handle_int_done = 1'b0;
    checks++; if (st_a !== 5'b00000) begin errors++; $display("FAIL areset_after: got %b want 00000", st_a); end
  endtask

  task automatic test_random();
    int unsigned m_ph;   // 0 idle, 1 waiting for boundary, 2 inject, 3 servicing, 4 iretd hold
    int unsigned m_age;
    logic        m_pend, m_ack, m_terr, clr, bnd;
    logic [7:0]  m_vec;
    logic [4:0]  exp_st;
    do_reset();
    m_ph = 0; m_age = 0; m_pend = 1'b0; m_ack = 1'b0; m_terr = 1'b0; m_vec = 8'h00;
    for (int cyc = 0; cyc < 800; cyc++) begin
      ifa.int_req           = ($urandom_range(99, 0) < 30);
      ifa.int_vector        = VECW'($urandom());
      ifa.eflags_reg        = {22'($urandom()), ($urandom_range(99, 0) < 70), 9'($urandom())};
      ifa.s0_valid          = ($urandom_range(99, 0) < 50);
      ifa.s0_ready          = ($urandom_range(99, 0) < 60);
      ifa.s0_rom_in_control = ($urandom_range(99, 0) < 20);
      ifa.iretd             = ($urandom_range(99, 0) < 10);
      ifa.iretd_done        = ($urandom_range(99, 0) < 15);
      ifa.flush             = ($urandom_range(99, 0) < 10);
      ifa.handle_int_done   = ($urandom_range(99, 0) < 20);
      @(posedge clk);
      bnd = !ifa.s0_rom_in_control && (!ifa.s0_valid || ifa.s0_ready);
      clr = 1'b0;
      m_ack = 1'b0;
      case (m_ph)
        0: if (ifa.s0_valid && ifa.iretd) m_ph = 4; else if (m_pend) m_ph = 1;
        1: if (!ifa.flush && bnd) m_ph = 2;
        2: begin m_ph = 3; m_age = 0; end
        3: begin
          if (ifa.handle_int_done) begin m_ph = 0; m_ack = 1'b1; clr = 1'b1; end
          else if (m_age + 1 == TO_A) begin m_ph = 0; m_terr = 1'b1; clr = 1'b1; end
          else m_age++;
        end
        default: if (ifa.iretd_done || ifa.flush) m_ph = 0;
      endcase
      if (clr) m_pend = 1'b0;
      else if (!m_pend && ifa.int_req && ifa.eflags_reg[9]) begin
        m_pend = 1'b1;
        m_vec  = ifa.int_vector;
      end
      exp_st = {(m_ph == 2 || m_ph == 3), (m_ph == 4), m_ack, (m_ph != 0), m_terr};
      @(negedge clk);
      checks++; if (st_a !== exp_st) begin errors++; $display("FAIL rand_status[%0d]: got %b want %b", cyc, st_a, exp_st); end
      checks++; if (ifa.int_vector_q !== m_vec) begin errors++; $display("FAIL rand_vec[%0d]: got %h want %h", cyc, ifa.int_vector_q, m_vec); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_if_mask();
    test_boundary();
    test_iretd();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
